// File: rtl/riscv_regfile_sb.sv
// riscv_regfile_sb: register file with per-register busy scoreboard, write-back bypass and stall detection.
module riscv_regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NRD = 2,
  localparam int AW = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              issue_valid_i,
  input  logic [AW-1:0]     issue_rd_i,
  input  logic              wb_en_i,
  input  logic [AW-1:0]     wb_addr_i,
  input  logic [XLEN-1:0]   wb_data_i,
  input  logic              flush_i,
  input  logic [NRD-1:0]    rd_en_i,
  input  logic [NRD*AW-1:0] rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]    rd_busy_o,
  output logic              stall_o,
  output logic [AW:0]       busy_cnt_o
);
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy, busyNext;
  logic [AW:0] cntNext;
  always_comb begin
    busyNext = busy;
    if (wb_en_i) busyNext[wb_addr_i] = 1'b0;
    if (issue_valid_i) busyNext[issue_rd_i] = 1'b1;
    if (flush_i) busyNext = '0;
    busyNext[0] = 1'b0;
  end
  always_comb begin
    cntNext = '0;
    for (int i = 0; i < NREGS; i++) cntNext += {{AW{1'b0}}, busyNext[i]};
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      busy <= '0;
      busy_cnt_o <= '0;
    end else begin
      busy <= busyNext;
      busy_cnt_o <= cntNext;
    end
  // x0 is cleared by reset and never written afterwards, so it always reads zero
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (wb_en_i && wb_addr_i != '0) begin
      regs[wb_addr_i] <= wb_data_i;
    end
  for (genvar p = 0; p < NRD; p++) begin : g_port
    logic [AW-1:0] addr;
    logic [XLEN-1:0] q;
    logic hit;
    assign addr = rd_addr_i[p*AW +: AW];
    assign hit = wb_en_i && wb_addr_i == addr && addr != '0;
    assign rd_busy_o[p] = rd_en_i[p] & busy[addr] & ~(wb_en_i & (wb_addr_i == addr));
    always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) q <= '0;
      else if (rd_en_i[p] && !rd_busy_o[p]) q <= hit ? wb_data_i : regs[addr];
    assign rd_data_o[p*XLEN +: XLEN] = q;
  end
  assign stall_o = |rd_busy_o;
endmodule

// File: tb/tb_riscv_regfile_sb.sv
// tb_riscv_regfile_sb: directed and randomised checks of riscv_regfile_sb against an array-based scoreboard model.
module tb_riscv_regfile_sb;
  localparam int XLEN = 32, NREGS = 32, NRD = 2, AW = 5;
  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic issue_valid_i, wb_en_i, flush_i;
  logic [AW-1:0] issue_rd_i, wb_addr_i;
  logic [XLEN-1:0] wb_data_i;
  logic [NRD-1:0] rd_en_i;
  logic [NRD*AW-1:0] rd_addr_i;
  logic [NRD*XLEN-1:0] rd_data_o;
  logic [NRD-1:0] rd_busy_o;
  logic stall_o;
  logic [AW:0] busy_cnt_o;
  int total = 0, bad = 0;
  logic [XLEN-1:0] mRegs [NREGS] = '{default: '0};
  bit mBusy [NREGS] = '{default: 1'b0};
  logic [XLEN-1:0] mRd [NRD] = '{default: '0};

  riscv_regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
    .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .flush_i(flush_i),
    .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .rd_busy_o(rd_busy_o),
    .stall_o(stall_o), .busy_cnt_o(busy_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit expBusy(int p);
    logic [AW-1:0] a;
    a = rd_addr_i[p*AW +: AW];
    return rd_en_i[p] && a != 0 && mBusy[a] && !(wb_en_i && wb_addr_i == a);
  endfunction

  function automatic int mCount();
    int n = 0;
    for (int i = 0; i < NREGS; i++) n += int'(mBusy[i]);
    return n;
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) begin
        mRegs[i] = '0;
        mBusy[i] = 1'b0;
      end
      for (int p = 0; p < NRD; p++) mRd[p] = '0;
    end else begin
      for (int p = 0; p < NRD; p++) begin
        logic [AW-1:0] a;
        a = rd_addr_i[p*AW +: AW];
        if (rd_en_i[p] && !expBusy(p))
          mRd[p] = (wb_en_i && wb_addr_i == a && a != 0) ? wb_data_i : mRegs[a];
      end
      if (wb_en_i) mBusy[wb_addr_i] = 1'b0;
      if (issue_valid_i && issue_rd_i != 0) mBusy[issue_rd_i] = 1'b1;
      if (flush_i) for (int i = 0; i < NREGS; i++) mBusy[i] = 1'b0;
      if (wb_en_i && wb_addr_i != 0) mRegs[wb_addr_i] = wb_data_i;
    end
  end

  always @(negedge clk_i) begin
    logic [NRD-1:0] eb;
    for (int p = 0; p < NRD; p++) begin
      eb[p] = expBusy(p);
      chk("cmp_rd_data", 64'(rd_data_o[p*XLEN +: XLEN]), 64'(mRd[p]));
    end
    chk("cmp_rd_busy", 64'(rd_busy_o), 64'(eb));
    chk("cmp_stall", 64'(stall_o), 64'(|eb));
    chk("cmp_busy_cnt", 64'(busy_cnt_o), 64'(mCount()));
  end

  task automatic idle();
    issue_valid_i = 0; issue_rd_i = '0; wb_en_i = 0; wb_addr_i = '0; wb_data_i = '0;
    flush_i = 0; rd_en_i = '0; rd_addr_i = '0;
  endtask
  task automatic tick();
    @(posedge clk_i); #1; idle();
  endtask
  task automatic wb(int a, logic [XLEN-1:0] d);
    wb_en_i = 1; wb_addr_i = AW'(a); wb_data_i = d;
  endtask
  task automatic iss(int a);
    issue_valid_i = 1; issue_rd_i = AW'(a);
  endtask
  task automatic rd(int p, int a);
    rd_en_i[p] = 1'b1; rd_addr_i[p*AW +: AW] = AW'(a);
  endtask

  initial begin
    idle();
    @(posedge clk_i); #1;
    chk("reset_rd_data", 64'(rd_data_o), 64'h0);
    chk("reset_cnt", 64'(busy_cnt_o), 64'h0);
    @(posedge clk_i); #2 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    wb(5, 32'hDEADBEEF); tick();
    rd(0, 5); #2;
    chk("x5_rd_busy", 64'(rd_busy_o), 64'h0);
    tick();
    chk("x5_read", 64'(rd_data_o[31:0]), 64'hDEADBEEF);
    wb(0, 32'h12345678); tick();
    rd(0, 0); rd(1, 0); tick();
    chk("x0_p0", 64'(rd_data_o[31:0]), 64'h0);
    chk("x0_p1", 64'(rd_data_o[63:32]), 64'h0);
    chk("x0_cnt", 64'(busy_cnt_o), 64'h0);
    iss(7); tick();
    chk("x7_cnt", 64'(busy_cnt_o), 64'h1);
    rd(0, 7); #2;
    chk("x7_busy", 64'(rd_busy_o), 64'h1);
    chk("x7_stall", 64'(stall_o), 64'h1);
    tick();
    chk("x7_hold", 64'(rd_data_o[31:0]), 64'h0);
    wb(7, 32'hA5A5A5A5); rd(0, 7); #2;
    chk("x7_wb_busy", 64'(rd_busy_o), 64'h0);
    tick();
    chk("x7_bypass", 64'(rd_data_o[31:0]), 64'hA5A5A5A5);
    chk("x7_cnt_clr", 64'(busy_cnt_o), 64'h0);
    iss(3); wb(3, 32'h33333333); tick();
    chk("x3_cnt", 64'(busy_cnt_o), 64'h1);
    rd(1, 3); #2;
    chk("x3_busy", 64'(rd_busy_o), 64'h2);
    tick();
    flush_i = 1; tick();
    rd(1, 3); tick();
    chk("x3_data", 64'(rd_data_o[63:32]), 64'h33333333);
    iss(1); tick(); iss(2); tick(); iss(4); tick();
    chk("three_cnt", 64'(busy_cnt_o), 64'h3);
    flush_i = 1; iss(9); tick();
    chk("flush_cnt", 64'(busy_cnt_o), 64'h0);
    rd(0, 9); rd(1, 1); #2;
    chk("flush_stall", 64'(stall_o), 64'h0);
    tick();
    rd(0, 5); rd(1, 5); tick();
    chk("same_p0", 64'(rd_data_o[31:0]), 64'hDEADBEEF);
    chk("same_p1", 64'(rd_data_o[63:32]), 64'hDEADBEEF);
    for (int n = 0; n < 300; n++) begin
      issue_valid_i = ($urandom_range(0, 2) == 0); issue_rd_i = AW'($urandom);
      wb_en_i = ($urandom_range(0, 2) == 0); wb_addr_i = AW'($urandom_range(0, 7)); wb_data_i = $urandom;
      flush_i = ($urandom_range(0, 19) == 0);
      rd_en_i = NRD'($urandom); rd_addr_i = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      tick();
    end
    flush_i = 1; tick();
    for (int i = 1; i < NREGS; i++) begin
      wb(i, 32'h01010101 * i); iss(i); tick();
    end
    chk("fill_cnt", 64'(busy_cnt_o), 64'd31);
    rd(0, 3); #2;
    chk("fill_stall", 64'(stall_o), 64'h1);
    #1 rst_ni = 1'b0;
    #1;
    chk("arst_rd_data", 64'(rd_data_o), 64'h0);
    chk("arst_cnt", 64'(busy_cnt_o), 64'h0);
    chk("arst_stall", 64'(stall_o), 64'h0);
    @(posedge clk_i); #2 rst_ni = 1'b1;
    idle(); rd(0, 5); tick();
    chk("post_rst_x5", 64'(rd_data_o[31:0]), 64'h0);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/riscv_regfile_sb.md
RISCV_REGFILE_SB -- requirements
Module: riscv_regfile_sb

Interface
REQ-001 Parameter XLEN, default 32, data width of each register.
REQ-002 Parameter NREGS, default 32, number of architectural registers; power of two, >= 2.
REQ-003 Parameter NRD, default 2, number of read ports.
REQ-004 Derived parameter AW = clog2(NREGS), address width.
REQ-005 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-006 rst_ni  in  1  asynchronous reset, active-low.
REQ-007 issue_valid_i  in  1  reserve destination issue_rd_i: set its busy bit.
REQ-008 issue_rd_i  in  AW  destination register being reserved.
REQ-009 wb_en_i  in  1  write-back strobe.
REQ-010 wb_addr_i  in  AW  write-back register.
REQ-011 wb_data_i  in  XLEN  write-back data.
REQ-012 flush_i  in  1  clear all busy bits; register contents untouched.
REQ-013 rd_en_i  in  NRD  per-port read enable.
REQ-014 rd_addr_i  in  NRD*AW  per-port read address; port p at bits [p*AW +: AW].
REQ-015 rd_data_o  out  NRD*XLEN  registered read data; port p at bits [p*XLEN +: XLEN].
REQ-016 rd_busy_o  out  NRD  combinational; port p's enabled address is busy and not resolved this cycle.
REQ-017 stall_o  out  1  combinational OR of rd_busy_o.
REQ-018 busy_cnt_o  out  AW+1  registered count of set busy bits.

Function
REQ-019 Register 0 SHALL always read 0, ignore writes, and never become busy.
REQ-020 A write SHALL occur at the clock edge when wb_en_i=1 and wb_addr_i!=0.
REQ-021 Read latency SHALL be 1 cycle: rd_data_o[p] updates at the edge following sampling of rd_en_i[p]=1.
REQ-022 rd_data_o[p] SHALL hold its value when rd_en_i[p]=0.
REQ-023 Bypass: if rd_addr[p]==wb_addr_i!=0 and wb_en_i=1 in the same cycle, rd_data_o[p] SHALL capture wb_data_i.
REQ-024 Busy set: issue_valid_i=1 with issue_rd_i!=0 sets busy[issue_rd_i] at the edge.
REQ-025 Busy clear: wb_en_i=1 clears busy[wb_addr_i] at the edge.
REQ-026 Simultaneous set and clear of the same address: set SHALL win, leaving the bit at 1.
REQ-027 flush_i=1 SHALL clear all busy bits at the edge; flush has priority over issue in the same cycle.
REQ-028 Write-back to a non-busy register SHALL still write data; busy stays 0.
REQ-029 rd_busy_o[p] = rd_en_i[p] & busy[rd_addr[p]] & ~(wb_en_i & wb_addr_i==rd_addr[p]); always 0 for address 0.
REQ-030 When rd_busy_o[p]=1, rd_data_o[p] SHALL hold its previous value, since no stale data is captured.
REQ-031 busy_cnt_o SHALL equal the popcount of the busy vector after each edge, range 0..NREGS-1.
REQ-032 Multiple read ports addressing the same register SHALL each return the same value.

Reset
REQ-033 While rst_ni=0: all registers, busy bits, rd_data_o, and busy_cnt_o SHALL be 0, regardless of clock.
REQ-034 Reset assertion mid-operation SHALL discard pending reservations; deassertion is synchronised externally, and the first active edge behaves as REQ-019..REQ-032.

Verification
REQ-035 Write x5=0xDEADBEEF; next cycle read port0 x5 -> rd_data_o[0]=0xDEADBEEF one edge later; rd_busy_o=0.
REQ-036 Write x0=0x12345678; then read x0 on both ports -> both 0; busy_cnt_o=0.
REQ-037 Issue x7; read x7 on the next cycle -> rd_busy_o[0]=1, stall_o=1, and rd_data_o[0] holds; write-back x7=0xA5A5A5A5 with a read in the same cycle -> rd_busy_o[0]=0 and rd_data_o[0]=0xA5A5A5A5 next edge.
REQ-038 Issue x3 and write back x3 in the same cycle -> busy[3]=1, busy_cnt_o=1, and data written.
REQ-039 Issue x1, x2, x4 -> busy_cnt_o=3; then flush_i=1 with issue x9 -> busy_cnt_o=0 and no read stalls.
REQ-040 Fill registers, then pull rst_ni low between edges -> all outputs 0 immediately; after release, read x5=0.
